// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and glyph lookup for the seven-segment scan driver.
// Holds the 16-entry gfedcba (active-low) tables for plain hex and password
// glyphs, the all-dark segment constant, and the glyph(nibble, mode) helper.
package seg7_pkg;

  // All segments and DP dark (active-low outputs).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the gfedcba code for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Password glyphs: 0xB renders as 'r', 0xC as 'P'; all else as hex.
  localparam logic [15:0][6:0] GLYPH_PWD = {
    7'h0E, 7'h06, 7'h21, 7'h0C, 7'h2F, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic mode);
    return mode ? GLYPH_PWD[nibble] : GLYPH_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: nibble + glyph mode -> active-low gfedcba segment code.
// Latency: combinational. Backpressure: none (pure lookup).
// Ports: nibble (4b digit value), mode (0 = hex, 1 = password glyphs), seg (7b gfedcba, active-low).
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       mode,
  output logic [6:0] seg
);

  assign seg = glyph(nibble, mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with frame-synchronous commit.
// Latency: outputs registered, one cycle behind the scan state; load shows within 2 frames.
// Backpressure: none; load is a strobe into a pending register, the last load per frame wins.
// Ports: clk, rst (sync, active-high), load/value/dp/blank (pending capture),
//        seg_n (DP + gfedcba, active-low), an_n (digit enables, active-low), frame_done (boundary pulse).
// Optional: define SEG7_LZ_SUPPRESS_EN to dark leading zero digits (mask built at commit time).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 64,
  parameter int GLYPH_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             MODE_BIT = (GLYPH_MODE != 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;

  logic       slot_end;
  logic       boundary;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_dark;
  logic [6:0] cur_glyph;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Pending capture and frame-boundary commit. The commit reads pending
  // before this cycle's load lands, so a boundary-coincident load waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
      end
      if (boundary) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] sup_next, disp_sup;
  logic                  lz_chain;

  // Walk from the most significant digit down; the chain stays alive while
  // every digit above is dark (suppressed or blanked). Digit 0 never drops.
  always_comb begin
    sup_next = '0;
    lz_chain = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      sup_next[i] = lz_chain && (pend_value[4*i +: 4] == 4'd0) && !pend_dp[i];
      lz_chain    = sup_next[i] || pend_blank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           disp_sup <= '0;
    else if (boundary) disp_sup <= sup_next;
  end

  assign cur_dark = disp_blank[idx] || disp_sup[idx];
`else
  assign cur_dark = disp_blank[idx];
`endif

  assign cur_nib = 4'(disp_value >> {idx, 2'b00});
  assign cur_dp  = disp_dp[idx];

  seg7_glyph_rom u_rom (
    .nibble (cur_nib),
    .mode   (MODE_BIT),
    .seg    (cur_glyph)
  );

  // Registered pins: dead-time gap at slot start, blank keeps the anode off all slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n      <= SEG_OFF;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if ((cnt < DEAD_END) || cur_dark) begin
        seg_n <= SEG_OFF;
        an_n  <= '1;
      end else begin
        seg_n <= {~cur_dp, cur_glyph};
        an_n  <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (hex and password glyph modes) share stimulus.
// NUM_DIGITS 4, SCAN_DIV 8, DEAD_CYCLES 2 -> 32-cycle frames; every cycle of a checked frame is compared.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [7:0]  seg_n0, seg_n1;
  logic [3:0]  an_n0, an_n1;
  logic        fd0, fd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .GLYPH_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg_n(seg_n0), .an_n(an_n0), .frame_done(fd0)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .GLYPH_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg_n(seg_n1), .an_n(an_n1), .frame_done(fd1)
  );

  // Expected lit-phase seg_n per digit {d3,d2,d1,d0}; 8'hFF means the digit stays dark.
  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] seg_m0;
    logic [3:0][7:0] seg_m1;
  } vec_t;

  vec_t vecs[6];
  localparam logic [3:0][7:0] ALL_DARK = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [3:0][7:0] ALL_A    = {8'h88, 8'h88, 8'h88, 8'h88};

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {seg,an,fd}=%h required %h", name, act, exp);
    end
  endtask

  task automatic apply_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd0 && n < 100);
    if (!fd0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: frame_done timeout after %0d cycles", name, n);
    end
  endtask

  // Called on the negedge where frame_done is high; checks the following 32 cycles.
  task automatic check_frame(input logic [3:0][7:0] s0, input logic [3:0][7:0] s1, input string name);
    int slot, c;
    logic [7:0] e0, e1;
    logic [3:0] ean;
    logic       efd;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      slot = (k - 1) / 8;
      c    = (k - 1) % 8;
      efd  = (k == 32);
      if (c < 2 || s0[slot] == 8'hFF) begin
        e0 = 8'hFF; e1 = 8'hFF; ean = 4'hF;
      end else begin
        e0 = s0[slot]; e1 = s1[slot]; ean = ~(4'b0001 << slot);
      end
      check($sformatf("%s m0 cyc%0d", name, k), {seg_n0, an_n0, fd0}, {e0, ean, efd});
      check($sformatf("%s m1 cyc%0d", name, k), {seg_n1, an_n1, fd1}, {e1, ean, efd});
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h00BC, 4'b1100, 4'b0000, {8'h40, 8'h40, 8'h83, 8'hC6}, {8'h40, 8'h40, 8'hAF, 8'h8C}};
    vecs[2] = '{16'h5678, 4'b0100, 4'b0100, {8'h92, 8'hFF, 8'hF8, 8'h80}, {8'h92, 8'hFF, 8'hF8, 8'h80}};
    vecs[3] = '{16'h9DEF, 4'b0001, 4'b0000, {8'h98, 8'hA1, 8'h86, 8'h0E}, {8'h98, 8'hA1, 8'h86, 8'h0E}};
`ifdef SEG7_LZ_SUPPRESS_EN
    vecs[4] = '{16'h0070, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'hF8, 8'hC0}, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
`else
    vecs[4] = '{16'h0070, 4'b0000, 4'b0000, {8'hC0, 8'hC0, 8'hF8, 8'hC0}, {8'hC0, 8'hC0, 8'hF8, 8'hC0}};
`endif
    vecs[5] = '{16'h0070, 4'b1000, 4'b0000, {8'h40, 8'hC0, 8'hF8, 8'hC0}, {8'h40, 8'hC0, 8'hF8, 8'hC0}};

    // Reset state on the pins.
    repeat (2) @(negedge clk);
    check("reset m0", {seg_n0, an_n0, fd0}, {8'hFF, 4'hF, 1'b0});
    check("reset m1", {seg_n1, an_n1, fd1}, {8'hFF, 4'hF, 1'b0});
    rst = 1'b0;

    // Nothing loaded yet: the first frame is fully dark.
    wait_fd("first frame");
    check_frame(ALL_DARK, ALL_DARK, "dark");

    // Table: a throwaway load followed by the real one in the same frame; the last wins.
    for (int i = 0; i < 6; i++) begin
      apply_load(16'hEEEE, 4'hF, 4'h0);
      apply_load(vecs[i].value, vecs[i].dp, vecs[i].blank);
      wait_fd($sformatf("vec%0d", i));
      check_frame(vecs[i].seg_m0, vecs[i].seg_m1, $sformatf("vec%0d", i));
    end

    // Load on the boundary cycle: held a full extra frame.
    repeat (31) @(negedge clk);
    apply_load(16'hAAAA, 4'h0, 4'h0);
    check("bnd fd", {seg_n0, an_n0, fd0}, {seg_n0, an_n0, 1'b1});
    check_frame(vecs[5].seg_m0, vecs[5].seg_m1, "bnd old");
    check_frame(ALL_A, ALL_A, "bnd new");

    // Mid-slot reset with uncommitted pending data.
    apply_load(16'h1111, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("pre-rst lit", {5'b0, an_n0, 4'b0}, {5'b0, 4'b1110, 4'b0});
    rst = 1'b1;
    @(negedge clk);
    check("rst mid m0", {seg_n0, an_n0, fd0}, {8'hFF, 4'hF, 1'b0});
    check("rst mid m1", {seg_n1, an_n1, fd1}, {8'hFF, 4'hF, 1'b0});
    rst = 1'b0;
    wait_fd("post-rst");
    check_frame(ALL_DARK, ALL_DARK, "post-rst dark");
    apply_load(vecs[0].value, vecs[0].dp, vecs[0].blank);
    wait_fd("post-rst load");
    check_frame(vecs[0].seg_m0, vecs[0].seg_m1, "post-rst vec0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
